// File: rtl/alu_mdu.sv
// Integer execute unit: single-cycle ALU/branch ops plus a pipelined-latency
// multiplier and a restoring iterative divider sharing one broadcast port.
module alu_mdu #(
  parameter int XLEN    = 32,
  parameter int ENTRY_W = 4,
  parameter int MUL_LAT = 3,
  parameter int M_EN    = 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [5:0]         op,
  input  logic [XLEN-1:0]    vj,
  input  logic [XLEN-1:0]    vk,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    pc,
  input  logic [ENTRY_W-1:0] entry,
  output logic               alu_broadcast,
  output logic [XLEN-1:0]    alu_result,
  output logic [XLEN-1:0]    alu_pc_out,
  output logic [ENTRY_W-1:0] alu_entry,
  output logic [1:0]         o_dbg_state
);

  localparam logic [5:0] OP_ADD  = 6'd0,  OP_SUB   = 6'd1,  OP_SLL   = 6'd2,  OP_SLT   = 6'd3;
  localparam logic [5:0] OP_SLTU = 6'd4,  OP_XOR   = 6'd5,  OP_SRL   = 6'd6,  OP_SRA   = 6'd7;
  localparam logic [5:0] OP_OR   = 6'd8,  OP_AND   = 6'd9,  OP_ADDI  = 6'd10, OP_SLTI  = 6'd11;
  localparam logic [5:0] OP_SLTIU= 6'd12, OP_XORI  = 6'd13, OP_ORI   = 6'd14, OP_ANDI  = 6'd15;
  localparam logic [5:0] OP_SLLI = 6'd16, OP_SRLI  = 6'd17, OP_SRAI  = 6'd18, OP_LUI   = 6'd19;
  localparam logic [5:0] OP_AUIPC= 6'd20, OP_JAL   = 6'd21, OP_JALR  = 6'd22, OP_BEQ   = 6'd23;
  localparam logic [5:0] OP_BNE  = 6'd24, OP_BLT   = 6'd25, OP_BGE   = 6'd26, OP_BLTU  = 6'd27;
  localparam logic [5:0] OP_BGEU = 6'd28;
  localparam logic [5:0] OP_MUL  = 6'd32, OP_MULH  = 6'd33, OP_MULHSU= 6'd34, OP_MULHU = 6'd35;
  localparam logic [5:0] OP_DIV  = 6'd36, OP_DIVU  = 6'd37, OP_REM   = 6'd38, OP_REMU  = 6'd39;

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN + MUL_LAT + 2) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [5:0]          r_op;
  logic [XLEN-1:0]     r_a, r_b, r_pc4;
  logic [ENTRY_W-1:0]  r_tag;
  logic [XLEN-1:0]     r_quo, r_rem, r_dvs;
  logic                r_neg_q, r_neg_r, r_dz;
  logic                r_bcast;
  logic [XLEN-1:0]     r_result, r_pc_out;
  logic [ENTRY_W-1:0]  r_out_entry;

  // Handshake: an op is taken on issue_valid & issue_ready & rdy_in & ~clear;
  // issue_ready is high only in IDLE, so long ops block further issue.
  logic w_accept, w_is_mul, w_is_div;
  assign issue_ready = (r_state == S_IDLE);
  assign w_accept    = issue_valid & issue_ready & rdy_in & ~clear;
  assign w_is_mul    = (M_EN != 0) && (op[5:2] == 4'b1000);
  assign w_is_div    = (M_EN != 0) && (op[5:2] == 4'b1001);

  // ---------------- single-cycle ALU / branch ----------------
  logic [XLEN-1:0] w_pc4, w_pc_imm, w_jalr, w_alu_res, w_alu_pc;
  logic [SH_W-1:0] w_sh_r, w_sh_i;
  logic            w_take;
  assign w_pc4    = pc + XLEN'(4);
  assign w_pc_imm = pc + imm;
  assign w_jalr   = vj + imm;
  assign w_sh_r   = vk[SH_W-1:0];
  assign w_sh_i   = imm[SH_W-1:0];

  always_comb begin
    w_take = 1'b0;
    case (op)
      OP_BEQ:  w_take = (vj == vk);
      OP_BNE:  w_take = (vj != vk);
      OP_BLT:  w_take = ($signed(vj) <  $signed(vk));
      OP_BGE:  w_take = ($signed(vj) >= $signed(vk));
      OP_BLTU: w_take = (vj <  vk);
      OP_BGEU: w_take = (vj >= vk);
      default: w_take = 1'b0;
    endcase
  end

  always_comb begin
    w_alu_res = '0;
    w_alu_pc  = w_pc4;
    case (op)
      OP_ADD:   w_alu_res = vj + vk;
      OP_SUB:   w_alu_res = vj - vk;
      OP_SLL:   w_alu_res = vj << w_sh_r;
      OP_SLT:   w_alu_res = {{(XLEN-1){1'b0}}, ($signed(vj) < $signed(vk))};
      OP_SLTU:  w_alu_res = {{(XLEN-1){1'b0}}, (vj < vk)};
      OP_XOR:   w_alu_res = vj ^ vk;
      OP_SRL:   w_alu_res = vj >> w_sh_r;
      OP_SRA:   w_alu_res = $signed(vj) >>> w_sh_r;
      OP_OR:    w_alu_res = vj | vk;
      OP_AND:   w_alu_res = vj & vk;
      OP_ADDI:  w_alu_res = vj + imm;
      OP_SLTI:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(vj) < $signed(imm))};
      OP_SLTIU: w_alu_res = {{(XLEN-1){1'b0}}, (vj < imm)};
      OP_XORI:  w_alu_res = vj ^ imm;
      OP_ORI:   w_alu_res = vj | imm;
      OP_ANDI:  w_alu_res = vj & imm;
      OP_SLLI:  w_alu_res = vj << w_sh_i;
      OP_SRLI:  w_alu_res = vj >> w_sh_i;
      OP_SRAI:  w_alu_res = $signed(vj) >>> w_sh_i;
      OP_LUI:   w_alu_res = imm;
      OP_AUIPC: w_alu_res = w_pc_imm;
      OP_JAL: begin
        w_alu_res = w_pc4;
        w_alu_pc  = w_pc_imm;
      end
      OP_JALR: begin
        w_alu_res = w_pc4;
        w_alu_pc  = w_jalr & ~{{(XLEN-1){1'b0}}, 1'b1};
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        w_alu_res = {{(XLEN-1){1'b0}}, w_take};
        w_alu_pc  = w_take ? w_pc_imm : w_pc4;
      end
      default: ;
    endcase
  end

  // ---------------- multiplier ----------------
  // Live inputs feed the product only for MUL_LAT == 1, where the result is
  // registered in the acceptance cycle itself.
  logic [5:0]        w_mop;
  logic [XLEN-1:0]   w_ma, w_mb, w_mul_res;
  logic              w_a_sgn, w_b_sgn;
  logic [2*XLEN-1:0] w_ma_x, w_mb_x, w_prod;
  assign w_mop     = (r_state == S_IDLE) ? op : r_op;
  assign w_ma      = (r_state == S_IDLE) ? vj : r_a;
  assign w_mb      = (r_state == S_IDLE) ? vk : r_b;
  assign w_a_sgn   = (w_mop == OP_MULH) || (w_mop == OP_MULHSU);
  assign w_b_sgn   = (w_mop == OP_MULH);
  assign w_ma_x    = {{XLEN{w_a_sgn & w_ma[XLEN-1]}}, w_ma};
  assign w_mb_x    = {{XLEN{w_b_sgn & w_mb[XLEN-1]}}, w_mb};
  assign w_prod    = w_ma_x * w_mb_x;
  assign w_mul_res = (w_mop == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // ---------------- divider ----------------
  logic            w_sdiv, w_na, w_nb, w_rem_op, w_ge;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff, w_q_fix, w_r_fix, w_div_res;
  assign w_sdiv    = (op == OP_DIV) || (op == OP_REM);
  assign w_na      = w_sdiv & vj[XLEN-1];
  assign w_nb      = w_sdiv & vk[XLEN-1];
  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  assign w_diff    = w_shift[XLEN-1:0] - r_dvs;
  assign w_rem_op  = (r_op == OP_REM) || (r_op == OP_REMU);
  assign w_q_fix   = r_neg_q ? -r_quo : r_quo;
  assign w_r_fix   = r_neg_r ? -r_rem : r_rem;
  assign w_div_res = r_dz ? (w_rem_op ? r_a : '1) : (w_rem_op ? w_r_fix : w_q_fix);

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (rdy_in) begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mul)      w_next = S_MUL;
          else if (w_accept && w_is_div) w_next = S_DIV;
        end
        default: if (clear || r_bcast) w_next = S_IDLE;
      endcase
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt <= '0; r_op <= '0; r_a <= '0; r_b <= '0; r_pc4 <= '0; r_tag <= '0;
      r_quo <= '0; r_rem <= '0; r_dvs <= '0;
      r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_dz <= 1'b0;
      r_bcast <= 1'b0; r_result <= '0; r_pc_out <= '0; r_out_entry <= '0;
    end else if (rdy_in) begin
      r_bcast <= 1'b0;
      if (clear) begin
        r_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (w_accept) begin
            r_op  <= op;
            r_a   <= vj;
            r_b   <= vk;
            r_pc4 <= w_pc4;
            r_tag <= entry;
            if (w_is_mul) begin
              r_cnt <= CNT_W'(1);
              if (MUL_LAT == 1) begin
                r_bcast     <= 1'b1;
                r_result    <= w_mul_res;
                r_pc_out    <= w_pc4;
                r_out_entry <= entry;
              end
            end else if (w_is_div) begin
              r_cnt   <= CNT_W'(1);
              r_quo   <= w_na ? -vj : vj;
              r_dvs   <= w_nb ? -vk : vk;
              r_rem   <= '0;
              r_neg_q <= w_na ^ w_nb;
              r_neg_r <= w_na;
              r_dz    <= (vk == '0);
            end else begin
              r_bcast     <= 1'b1;
              r_result    <= w_alu_res;
              r_pc_out    <= w_alu_pc;
              r_out_entry <= entry;
            end
          end
          S_MUL: begin
            if (r_bcast) begin
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_cnt == CNT_W'(MUL_LAT - 1)) begin
                r_bcast     <= 1'b1;
                r_result    <= w_mul_res;
                r_pc_out    <= r_pc4;
                r_out_entry <= r_tag;
              end
            end
          end
          S_DIV: begin
            if (r_bcast) begin
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_cnt <= CNT_W'(XLEN)) begin
                r_rem <= w_ge ? w_diff : w_shift[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], w_ge};
              end else begin
                r_bcast     <= 1'b1;
                r_result    <= w_div_res;
                r_pc_out    <= r_pc4;
                r_out_entry <= r_tag;
              end
            end
          end
          default: r_cnt <= '0;
        endcase
      end
    end
  end

  assign alu_broadcast = r_bcast;
  assign alu_result    = r_result;
  assign alu_pc_out    = r_pc_out;
  assign alu_entry     = r_out_entry;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter XLEN, 32, datapath width of operands, results and PC.
REQ-002 Parameter ENTRY_W, 4, width of the ROB/RS entry tag.
REQ-003 Parameter MUL_LAT, 3, multiply latency in cycles (>=1).
REQ-004 Parameter M_EN, 1, 1 enables the eight M-extension ops; 0 makes them behave as unknown ops.
REQ-005 clk_in  input  1  system clock.
REQ-006 rst_in  input  1  reset, asynchronous, active-high.
REQ-007 rdy_in  input  1  ready; when low all state holds.
REQ-008 clear  input  1  flush after misprediction; aborts in-flight work.
REQ-009 issue_valid  input  1  operation presented.
REQ-010 issue_ready  output  1  unit can accept an operation this cycle.
REQ-011 op  input  6  operation code from operaType.v, plus new codes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-012 vj, vk, imm, pc  input  XLEN each  operands, immediate, instruction PC.
REQ-013 entry  input  ENTRY_W  tag of issuing entry.
REQ-014 alu_broadcast  output  1  registered one-cycle result-valid pulse.
REQ-015 alu_result, alu_pc_out  output  XLEN each  result; branch/jump target.
REQ-016 alu_entry  output  ENTRY_W  tag of broadcast result.

Function
REQ-017 Acceptance SHALL occur when issue_valid & issue_ready & rdy_in & ~clear; op, operands and entry are captured at acceptance.
REQ-018 States SHALL be IDLE, MUL, DIV; IDLE->MUL on accepted multiply, IDLE->DIV on accepted divide/remainder, MUL/DIV->IDLE in the broadcast cycle or on clear.
REQ-019 issue_ready SHALL be 1 in IDLE and 0 in MUL and DIV.
REQ-020 Single-cycle ops (all non-M ops) SHALL broadcast in the cycle after acceptance (latency 1) and may be accepted every cycle.
REQ-021 Multiply ops SHALL broadcast exactly MUL_LAT cycles after acceptance; MULH/MULHSU/MULHU return the upper XLEN bits of the 2*XLEN signed/signed-unsigned/unsigned product, MUL the lower.
REQ-022 Divide ops SHALL use a restoring iterative divider, one quotient bit per cycle, broadcasting XLEN+2 cycles after acceptance.
REQ-023 Divisor zero SHALL give quotient all-ones (DIV, DIVU) and remainder = dividend (REM, REMU).
REQ-024 Signed overflow (vj = most negative, vk = -1) SHALL give DIV = vj, REM = 0.
REQ-025 Branches SHALL give alu_result 1 with alu_pc_out = pc+imm when taken, alu_result 0 with alu_pc_out = pc+4 when not taken.
REQ-026 JAL SHALL give alu_result pc+4, alu_pc_out pc+imm; JALR alu_result pc+4, alu_pc_out (vj+imm) with bit 0 cleared.
REQ-027 Shift amounts SHALL be the low log2(XLEN) bits of vk (R-type) or imm (I-type); SRA/SRAI arithmetic.
REQ-028 LUI SHALL return imm, AUIPC pc+imm; all arithmetic wraps modulo 2^XLEN.
REQ-029 Unknown op SHALL broadcast alu_result 0, alu_pc_out pc+4.
REQ-030 For non-branch/jump ops alu_pc_out SHALL be pc+4.
REQ-031 While rdy_in is low, every register including alu_broadcast SHALL hold; counters do not advance.
REQ-032 clear SHALL force alu_broadcast 0 next cycle, return to IDLE, discard in-flight multiply/divide; issue in the same cycle as clear is ignored.
REQ-033 alu_broadcast SHALL be 1 for exactly one rdy_in-high cycle per accepted, non-cleared operation.

Reset
REQ-034 While rst_in is high, regardless of clk_in: state IDLE, issue_ready 1, alu_broadcast 0, alu_result 0, alu_pc_out 0, alu_entry 0, counters 0.
REQ-035 Reset mid-divide SHALL abort it with no later broadcast.

Verification
REQ-036 ADD vj=0xFFFFFFFF vk=1 entry=5 -> next cycle broadcast, result 0x00000000, entry 5.
REQ-037 BNE vj=1 vk=2 pc=0x100 imm=0x20, then BEQ same operands next cycle -> results 1/0x120 then 0/0x104 on consecutive cycles.
REQ-038 MULHU vj=vk=0xFFFFFFFF -> issue_ready low 3 cycles, result 0xFFFFFFFE at cycle 3.
REQ-039 DIV vj=0x80000000 vk=0xFFFFFFFF -> result 0x80000000 at cycle 34; DIVU vk=0 -> 0xFFFFFFFF; REM vk=0 vj=7 -> 7.
REQ-040 DIVU accepted, clear at cycle 10 -> no broadcast, issue_ready 1 at cycle 11; rdy_in low cycles 3-5 during MUL -> broadcast delayed to cycle 6.
